alu_for_tb: RTL and testbench
=============================

Name: alu_for_tb

Overview:
- Registered 32-bit ALU for the Lab 1 ALU demonstration.
- Operand A is an 8-bit switch-style input `num1`, zero-extended to 32 bits.
- Operand B is the hard-wired constant 32'h0000_0001.
- A 3-bit `op` selects the operation; the result is captured into a register each clock and drives `results`, which feeds the display/bench path.

Parameters:
- WIDTH, 32, datapath and result width.
- IN_WIDTH, 8, width of `num1`, zero-extended to WIDTH.
- CONST_B, 32'h0000_0001, fixed second operand.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- op  input  3  operation select.
- num1  input  8  operand A before zero-extension.
- results  output  32  registered ALU result.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Operand A = {24'b0, num1}. Operand B = CONST_B = 1.
- op encoding; all arithmetic is modulo 2^32, with no carry or overflow outputs:
  - 000 ADD: A + B.
  - 001 SUB: A - B. Wraps on underflow, so num1=0 gives 32'hFFFF_FFFF.
  - 010 AND: A & B.
  - 011 OR: A | B.
  - 100 NOT: ~A, bitwise over all 32 bits; B is ignored.
  - 101 SLT: 32'd1 if $signed(A) < $signed(B), else 32'd0. With zero-extension this is 1 only when num1 = 0.
  - 110, 111: reserved, result 32'd0.
- Combinational result computed from the current op/num1. `results` register loads it on every rising clk edge; no enable, no handshake.
- Latency: exactly 1 cycle. A change in op/num1 is visible on `results` after the next rising edge.
- Inputs are sampled only at the clock edge. Changes between edges have no effect until the next edge.
- Reset:
  - When rst=1 at a rising edge, `results` loads 32'd0, overriding the op/num1 computation.
  - Reset may assert at any time, including mid-sequence. Recovery is on the first edge with rst=0, which loads the normal result.
- Before the first clock edge `results` is don't-care. The bench must not check it until the first edge.
- No X propagation into `results`: unknown op values fall into the reserved case (0).
- No internal state other than the 32-bit result register.

Test Plan:
- op=000, num1=8'h02 -> after one edge results=32'h0000_0003. Then op=001, num1=8'hFF -> 32'h0000_00FE.
- op=010, num1=8'hFE -> 32'h0000_0000. Then op=011, num1=8'hAA -> 32'h0000_00AB.
- op=100, num1=8'hF0 -> 32'hFFFF_FF0F. Then op=101, num1=8'h81 -> 32'h0000_0000. Then op=101, num1=8'h00 -> 32'h0000_0001.
- Wrap and reserved codes: op=001, num1=8'h00 -> 32'hFFFF_FFFF. op=110 and op=111 with any num1 -> 32'h0000_0000.
- Reset sequence:
  - Hold op=100, num1=8'h00 so results=32'hFFFF_FFFF.
  - Assert rst=1 between edges: results stays 32'hFFFF_FFFF until the next edge, then becomes 0 and stays 0 while rst=1.
  - Deassert rst: the next edge gives 32'hFFFF_FFFF again.
- Latency check: change op/num1 just after an edge -> results is unchanged until the following edge, then updates in one cycle (clock period 100 ns, inputs changed every 100 ns).

Source files
------------

// File: rtl/alu_for_tb.sv
// Registered 32-bit ALU for the Lab 1 demonstration.
// Operand A is the zero-extended switch input num1 and operand B is a fixed constant.
// The selected result is captured into the results register on every rising clock edge.
module alu_for_tb #(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 8,
    parameter logic [WIDTH-1:0] CONST_B = 32'h0000_0001
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          op,
    input  logic [IN_WIDTH-1:0] num1,
    output logic [WIDTH-1:0]    results
);

    // Operation encodings on the op select lines
    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpNot = 3'b100;
    localparam logic [2:0] OpSlt = 3'b101;

    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [WIDTH-1:0] nextResult;

    assign operandA = {{(WIDTH-IN_WIDTH){1'b0}}, num1};
    assign operandB = CONST_B;

    // Select the ALU result from the current inputs; reserved and unknown codes give zero
    always_comb begin
        nextResult = '0;
        case (op)
            OpAdd:   nextResult = operandA + operandB;
            OpSub:   nextResult = operandA - operandB;
            OpAnd:   nextResult = operandA & operandB;
            OpOr:    nextResult = operandA | operandB;
            OpNot:   nextResult = ~operandA;
            OpSlt:   nextResult = ($signed(operandA) < $signed(operandB)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
            default: nextResult = '0;
        endcase
    end

    // Capture the result every edge; synchronous reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            results <= '0;
        end else begin
            results <= nextResult;
        end
    end

endmodule

// File: tb/tb_alu_for_tb.sv
// Directed testbench for alu_for_tb with hand-computed expected results.
module tb_alu_for_tb;

    logic        clk;
    logic        rst;
    logic [2:0]  op;
    logic [7:0]  num1;
    logic [31:0] results;

    int testCount = 0;
    int failCount = 0;

    alu_for_tb dut (
        .clk     (clk),
        .rst     (rst),
        .op      (op),
        .num1    (num1),
        .results (results)
    );

    // 100 ns clock period
    initial begin
        clk = 1'b0;
        forever #50 clk = ~clk;
    end

    // Compare results against a hand-computed value
    task automatic checkOutput(input string tag, input logic [31:0] expected);
        testCount++;
        assert (results === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, results, expected);
        end
    endtask

    // Drive new inputs at the falling edge, then wait until just after the next rising edge
    task automatic applyStimulus(input logic [2:0] newOp, input logic [7:0] newNum1);
        @(negedge clk);
        op   = newOp;
        num1 = newNum1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        op   = 3'b000;
        num1 = 8'h00;

        @(posedge clk);
        #1;
        checkOutput("reset_state", 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(3'b000, 8'h02); checkOutput("add_02", 32'h0000_0003);
        applyStimulus(3'b001, 8'hFF); checkOutput("sub_ff", 32'h0000_00FE);
        applyStimulus(3'b010, 8'hFE); checkOutput("and_fe", 32'h0000_0000);
        applyStimulus(3'b011, 8'hAA); checkOutput("or_aa",  32'h0000_00AB);
        applyStimulus(3'b100, 8'hF0); checkOutput("not_f0", 32'hFFFF_FF0F);
        applyStimulus(3'b101, 8'h81); checkOutput("slt_81", 32'h0000_0000);
        applyStimulus(3'b101, 8'h00); checkOutput("slt_00", 32'h0000_0001);
        applyStimulus(3'b001, 8'h00); checkOutput("sub_wrap", 32'hFFFF_FFFF);
        applyStimulus(3'b110, 8'h5A); checkOutput("rsv_110", 32'h0000_0000);
        applyStimulus(3'b000, 8'hFF); checkOutput("add_ff", 32'h0000_0100);
        applyStimulus(3'b111, 8'hC3); checkOutput("rsv_111", 32'h0000_0000);

        // Reset sequence with the output held at all ones
        applyStimulus(3'b100, 8'h00); checkOutput("not_00", 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b1;
        #10;
        checkOutput("rst_before_edge", 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        checkOutput("rst_edge1", 32'h0000_0000);
        @(posedge clk);
        #1;
        checkOutput("rst_edge2", 32'h0000_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_recover", 32'hFFFF_FFFF);

        // Latency: a mid-cycle input change must not show until the next edge
        @(negedge clk);
        op   = 3'b000;
        num1 = 8'h10;
        #20;
        checkOutput("latency_hold", 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        checkOutput("latency_update", 32'h0000_0011);
        op   = 3'b011;
        num1 = 8'h40;
        #1;
        checkOutput("latency_hold2", 32'h0000_0011);
        @(posedge clk);
        #1;
        checkOutput("latency_update2", 32'h0000_0041);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
